// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between the
// instruction-fetch and data ports of an RV32I core, with a registered read-response path.
module unified_mem_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [AW-1:0]    if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [DW-1:0]    if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [AW-1:0]    d_addr,
    input  logic [DW-1:0]    d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [DW-1:0]    d_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [CNT_W-1:0] contention_cnt
);

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    logic             last_owner_q, last_owner_d;
    logic             resp_pending_q, resp_pending_d;
    logic             resp_owner_q, resp_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             both_req;
    logic             gnt_read;

    // On a tie the requester that did not own the port last time wins.
    assign both_req = if_req & d_req;
    assign if_gnt   = if_req & (~d_req | (last_owner_q == OWNER_D));
    assign d_gnt    = d_req & (~if_req | (last_owner_q == OWNER_IF));
    assign gnt_read = if_gnt | (d_gnt & ~d_we);

    assign mem_en    = if_gnt | d_gnt;
    assign mem_we    = d_gnt & d_we;
    assign mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : '0);
    assign mem_wdata = d_gnt ? d_wdata : '0;

    // Read data is shared; the rvalid strobes alone say whose it is.
    assign if_rvalid      = resp_pending_q & (resp_owner_q == OWNER_IF);
    assign d_rvalid       = resp_pending_q & (resp_owner_q == OWNER_D);
    assign if_rdata       = mem_rdata;
    assign d_rdata        = mem_rdata;
    assign contention_cnt = cnt_q;

    always_comb begin
        last_owner_d   = last_owner_q;
        resp_pending_d = gnt_read;
        resp_owner_d   = resp_owner_q;
        cnt_d          = cnt_q;
        if (if_gnt) begin
            last_owner_d = OWNER_IF;
        end else if (d_gnt) begin
            last_owner_d = OWNER_D;
        end
        if (gnt_read) begin
            resp_owner_d = d_gnt ? OWNER_D : OWNER_IF;
        end
        if (both_req && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q   <= OWNER_D;
            resp_pending_q <= 1'b0;
            resp_owner_q   <= OWNER_IF;
            cnt_q          <= '0;
        end else begin
            last_owner_q   <= last_owner_d;
            resp_pending_q <= resp_pending_d;
            resp_owner_q   <= resp_owner_d;
            cnt_q          <= cnt_d;
        end
    end

endmodule
